serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_fs_cell.sv | 17 +
 rtl/serial_subtractor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit combinational full subtractor: computes a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d         : difference bit
//   bout      : borrow out
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, one bit per clock, LSB first.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : operand handshake (a, b, borrow_in)
//   out_valid/out_ready       : result handshake (diff, borrow_out)
//   diff                      : (a - b - borrow_in) mod 2^WIDTH
//   borrow_out                : 1 iff a < b + borrow_in
//   busy                      : high while an operation is in RUN or DONE
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, a_sr_next;
  logic [WIDTH-1:0] b_sr_reg, b_sr_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             brw_reg, brw_next;
  logic             borrow_out_reg, borrow_out_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] result_shift;

  fs_cell u_fs_cell (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .bin  (brw_reg),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // New difference bit enters at the MSB; after WIDTH shifts the first
  // (LSB) bit has walked down to position 0.
  always_comb begin
    result_shift            = result_reg >> 1;
    result_shift[WIDTH-1]   = cell_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_sr_reg       <= '0;
      b_sr_reg       <= '0;
      result_reg     <= '0;
      diff_reg       <= '0;
      brw_reg        <= 1'b0;
      borrow_out_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      a_sr_reg       <= a_sr_next;
      b_sr_reg       <= b_sr_next;
      result_reg     <= result_next;
      diff_reg       <= diff_next;
      brw_reg        <= brw_next;
      borrow_out_reg <= borrow_out_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    a_sr_next       = a_sr_reg;
    b_sr_next       = b_sr_reg;
    result_next     = result_reg;
    diff_next       = diff_reg;
    brw_next        = brw_reg;
    borrow_out_next = borrow_out_reg;
    count_next      = count_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_sr_next  = a;
          b_sr_next  = b;
          brw_next   = borrow_in;
          count_next = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_sr_next   = a_sr_reg >> 1;
        b_sr_next   = b_sr_reg >> 1;
        result_next = result_shift;
        brw_next    = cell_bout;
        count_next  = count_reg + CNT_W'(1);
        if (count_reg == LAST_BIT) begin
          // Output registers are separate from the working result so the
          // presented value survives the next operation until it completes.
          diff_next       = result_shift;
          borrow_out_next = cell_bout;
          state_next      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready   = (state_reg == IDLE) && !rst;
  assign out_valid  = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);
  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;

endmodule
